// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   state_e  : responder FSM encoding
//   WORD_W   : data word width
//   addr_ok(): alignment and range rule for a byte address
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Word aligned and no address bits set above the word-index field.
    function automatic logic addr_ok(input logic [WORD_W-1:0] addr,
                                     input int unsigned       addr_w);
        logic [WORD_W-1:0] hi;
        hi = addr >> (addr_w + 2);
        return (addr[1:0] == 2'b00) && (hi == '0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage, synchronous byte-enabled write, combinational read.
//   clk      : rising-edge clock
//   we_i     : per-byte write enables (0 = no write)
//   addr_i   : word index for both read and write
//   wdata_i  : write data
//   rdata_o  : read data at addr_i (combinational)
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic [BE_W-1:0]   we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(BE_W); i++) begin
            if (we_i[i]) begin
                mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder of the CPU load/store interface with LATENCY wait states.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_we/addr/wdata/be  : request payload (store flag, byte address, data, byte enables)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata/rsp_err     : load data (0 for stores/errors), error flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic              commit_c;
    logic              accept_c;
    logic              sel_we_c;
    logic [WORD_W-1:0] sel_addr_c;
    logic              sel_ok_c;
    logic [BE_W-1:0]   mem_we_c;
    logic [WORD_W-1:0] mem_rdata_c;

    // A zero-latency commit happens on the accept edge, before the latches
    // are loaded, so the live request is used while in IDLE.
    assign sel_we_c   = (state_q == ST_IDLE) ? req_we   : we_q;
    assign sel_addr_c = (state_q == ST_IDLE) ? req_addr : addr_q;
    assign sel_ok_c   = addr_ok(sel_addr_c, ADDR_W);

    // Uncommitted stores must never land, even on a reset edge.
    assign mem_we_c = (commit_c && sel_we_c && sel_ok_c && !reset)
                    ? ((state_q == ST_IDLE) ? req_be : be_q) : '0;

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we_c),
        .addr_i  (sel_addr_c[ADDR_W+1:2]),
        .wdata_i ((state_q == ST_IDLE) ? req_wdata : wdata_q),
        .rdata_o (mem_rdata_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit_c    = 1'b0;
        accept_c    = req_valid && req_ready_q;

        unique case (state_q)
            ST_IDLE: begin
                // req_ready rises one cycle after returning to IDLE.
                req_ready_d = 1'b1;
                if (accept_c) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    be_d        = req_be;
                    req_ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        commit_c = 1'b1;
                        state_d  = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    commit_c = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Response payload is captured on the commit edge and then held.
        if (commit_c) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = !sel_ok_c;
            rsp_rdata_d = (!sel_we_c && sel_ok_c) ? mem_rdata_c : '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance plus a LATENCY=0 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;
    logic [3:0]  req_be0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(1024), .LATENCY(2), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(0), .ADDR_W(10)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // One LATENCY=2 transaction starting and ending at a negedge.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(negedge clk);
        // Scramble the request lines; the in-flight transaction must ignore them.
        req_valid = 1'b0; req_we = ~we; req_addr = 32'h0000_0044;
        req_wdata = $urandom; req_be = 4'hF;
        chk({tag, "/c1_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/c1_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({tag, "/c2_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk({tag, "/c3_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "/rdata"}, rsp_rdata, exp_rd);
        chk({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
            chk({tag, "/hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({tag, "/hold_ready"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "/done_ready"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        chk({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
    endtask

    logic        t6_we  [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] t6_adr [3] = '{32'h8, 32'h8, 32'h9};
    logic [31:0] t6_wd  [3] = '{32'h0BAD_CAFE, 32'h0, 32'h0};
    logic [31:0] t6_rd  [3] = '{32'h0, 32'h0BAD_CAFE, 32'h0};
    logic        t6_err [3] = '{1'b0, 1'b0, 1'b1};

    initial begin
        int n;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
        rsp_ready0 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst/req_ready", 32'(req_ready), 32'd1);
        chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst/rsp_rdata", rsp_rdata, 32'd0);
        chk("rst/rsp_err", 32'(rsp_err), 32'd0);
        chk("rst0/req_ready", 32'(req_ready0), 32'd1);
        chk("rst0/rsp_valid", 32'(rsp_valid0), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        txn("t1_st", 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 0);
        txn("t1_ld", 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 0);
        txn("t2_st", 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 0);
        txn("t2_ld", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 0);
        txn("be0_st", 1'b1, 32'h40, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 0);
        txn("be0_ld", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 0);

        txn("t3_misal", 1'b0, 32'h42, 32'h0, 4'hF, 32'h0, 1'b1, 0);
        txn("t3_st0", 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 0);
        txn("t3_range", 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 0);
        txn("t3_ld0", 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 0);

        txn("t4_hold", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 5);

        // Reset during WAIT of a store: the store must not land.
        txn("t5_pre", 1'b1, 32'h80, 32'h1122_3344, 4'hF, 32'h0, 1'b0, 0);
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5/ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h80; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5/wait_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5/rst_valid", 32'(rsp_valid), 32'd0);
        chk("t5/rst_ready", 32'(req_ready), 32'd1);
        txn("t5_ld", 1'b0, 32'h80, 32'h0, 4'h0, 32'h1122_3344, 1'b0, 0);

        // LATENCY=0 instance: back-to-back with rsp_ready held high.
        for (int i = 0; i < 3; i++) begin
            chk("t6/c0_ready", 32'(req_ready0), 32'd1);
            req_valid0 = 1'b1; req_we0 = t6_we[i]; req_addr0 = t6_adr[i];
            req_wdata0 = t6_wd[i]; req_be0 = 4'hF;
            @(negedge clk);
            chk("t6/c1_valid", 32'(rsp_valid0), 32'd1);
            chk("t6/c1_rdata", rsp_rdata0, t6_rd[i]);
            chk("t6/c1_err", 32'(rsp_err0), 32'(t6_err[i]));
            @(negedge clk);
            chk("t6/c2_valid", 32'(rsp_valid0), 32'd0);
            chk("t6/c2_ready", 32'(req_ready0), 32'd0);
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        chk("t6/end_ready", 32'(req_ready0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
